// File: rtl/lbc_pkg.sv
// Shared constants, FSM state type and fill-counter width for the line buffer controller.
package lbc_pkg;
  localparam int NUM_LB   = 4;
  localparam int WIN_ROWS = 3;

  typedef enum logic {IDLE, READ} state_t;

  // Fill must be able to represent every buffer completely full.
  function automatic int fill_width(input int line_w);
    return $clog2(NUM_LB * line_w + 1);
  endfunction
endpackage

// File: rtl/lbc_win_mux.sv
// Rotates the four buffer triples so that buffer rd_sel lands on the top row.
// Purely combinational; the caller registers the result.
module lbc_win_mux import lbc_pkg::*; #(
  parameter int DATA_W = 8
) (
  input  logic [1:0]                             rd_sel,
  input  logic [NUM_LB*WIN_ROWS*DATA_W-1:0]      lb_rd_data,
  output logic [WIN_ROWS*WIN_ROWS*DATA_W-1:0]    window
);
  localparam int TW = WIN_ROWS * DATA_W;

  logic [1:0] idx;

  always_comb begin
    window = '0;
    idx    = '0;
    for (int r = 0; r < WIN_ROWS; r++) begin
      idx = rd_sel + 2'(r);
      // Row 0 (top) occupies the most significant triple.
      window[(WIN_ROWS-1-r)*TW +: TW] = lb_rd_data[idx*TW +: TW];
    end
  end
endmodule

// File: rtl/line_buffer_ctrl.sv
// Round-robin writer / 3-row reader over four line buffers; window valid 1 cycle after rd_en.
// o_ready drops when all four lines are held; LBC_LINE_COUNT_EN adds the o_line_cnt output.
module line_buffer_ctrl import lbc_pkg::*; #(
  parameter int LINE_W = 256,
  parameter int DATA_W = 8
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [DATA_W-1:0]                  i_pixel_data,
  input  logic                               i_pixel_valid,
  output logic                               o_ready,
  output logic [DATA_W-1:0]                  o_lb_wr_data,
  output logic [NUM_LB-1:0]                  o_lb_wr_valid,
  output logic [NUM_LB-1:0]                  o_lb_rd_en,
  input  logic [NUM_LB*WIN_ROWS*DATA_W-1:0]  i_lb_rd_data,
  output logic [9*DATA_W-1:0]                o_pixel_data,
  output logic                               o_pixel_valid,
  output logic                               o_intr,
  output logic                               o_overflow
`ifdef LBC_LINE_COUNT_EN
  ,
  output logic [15:0]                        o_line_cnt
`endif
);
  localparam int CNT_W  = $clog2(LINE_W);
  localparam int FILL_W = fill_width(LINE_W);
  localparam logic [FILL_W-1:0] FULL   = FILL_W'(NUM_LB * LINE_W);
  localparam logic [FILL_W-1:0] THRESH = FILL_W'(WIN_ROWS * LINE_W);
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(LINE_W - 1);

  state_t                    state;
  logic [CNT_W-1:0]          wr_cnt;
  logic [CNT_W-1:0]          rd_cnt;
  logic [1:0]                wr_sel;
  logic [1:0]                rd_sel;
  logic [FILL_W-1:0]         fill;
  logic [FILL_W-1:0]         fill_nxt;
  logic                      accept;
  logic                      rd_cycle;
  logic [9*DATA_W-1:0]       window;

  assign o_ready       = (fill < FULL);
  assign accept        = i_pixel_valid & o_ready;
  assign rd_cycle      = (state == READ);
  assign o_lb_wr_data  = i_pixel_data;
  assign o_lb_wr_valid = accept ? (NUM_LB'(1) << wr_sel) : '0;

  always_comb begin
    o_lb_rd_en = '0;
    if (rd_cycle) begin
      for (int r = 0; r < WIN_ROWS; r++) begin
        o_lb_rd_en[rd_sel + 2'(r)] = 1'b1;
      end
    end
  end

  // A read cycle retires one pixel of the top line only.
  always_comb begin
    fill_nxt = fill;
    case ({accept, rd_cycle})
      2'b10:   fill_nxt = fill + FILL_W'(1);
      2'b01:   fill_nxt = fill - FILL_W'(1);
      default: fill_nxt = fill;
    endcase
  end

  lbc_win_mux #(.DATA_W(DATA_W)) u_win_mux (
    .rd_sel     (rd_sel),
    .lb_rd_data (i_lb_rd_data),
    .window     (window)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_cnt     <= '0;
      wr_sel     <= '0;
      fill       <= '0;
      o_overflow <= 1'b0;
    end else begin
      fill <= fill_nxt;
      if (i_pixel_valid && !o_ready) begin
        o_overflow <= 1'b1;
      end
      if (accept) begin
        if (wr_cnt == LAST) begin
          wr_cnt <= '0;
          wr_sel <= wr_sel + 2'd1;
        end else begin
          wr_cnt <= wr_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Deciding on fill_nxt lets READ start the cycle after the third line completes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      rd_cnt        <= '0;
      rd_sel        <= '0;
      o_pixel_data  <= '0;
      o_pixel_valid <= 1'b0;
      o_intr        <= 1'b0;
    end else begin
      o_pixel_valid <= rd_cycle;
      o_intr        <= rd_cycle && (rd_cnt == LAST);
      if (rd_cycle) begin
        o_pixel_data <= window;
      end
      case (state)
        IDLE: begin
          if (fill_nxt >= THRESH) begin
            state <= READ;
          end
        end
        READ: begin
          if (rd_cnt == LAST) begin
            state  <= IDLE;
            rd_cnt <= '0;
            rd_sel <= rd_sel + 2'd1;
          end else begin
            rd_cnt <= rd_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LBC_LINE_COUNT_EN
  logic [15:0] line_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      line_cnt <= '0;
    end else if (rd_cycle && (rd_cnt == LAST)) begin
      line_cnt <= line_cnt + 16'd1;
    end
  end

  assign o_line_cnt = line_cnt;
`endif
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl with LINE_W=4: buffer model plus write/window scoreboards.
module tb_line_buffer_ctrl;
  localparam int LW = 4;
  localparam int DW = 8;

  typedef struct packed {
    logic [9*DW-1:0] win;
    logic            intr;
  } exp_t;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic [DW-1:0]   i_pixel_data;
  logic            i_pixel_valid;
  logic            o_ready;
  logic [DW-1:0]   o_lb_wr_data;
  logic [3:0]      o_lb_wr_valid;
  logic [3:0]      o_lb_rd_en;
  logic [4*3*DW-1:0] i_lb_rd_data;
  logic [9*DW-1:0] o_pixel_data;
  logic            o_pixel_valid;
  logic            o_intr;
  logic            o_overflow;
`ifdef LBC_LINE_COUNT_EN
  logic [15:0]     o_line_cnt;
`endif

  always #5 i_clk = ~i_clk;

  line_buffer_ctrl #(.LINE_W(LW), .DATA_W(DW)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_pixel_data  (i_pixel_data),
    .i_pixel_valid (i_pixel_valid),
    .o_ready       (o_ready),
    .o_lb_wr_data  (o_lb_wr_data),
    .o_lb_wr_valid (o_lb_wr_valid),
    .o_lb_rd_en    (o_lb_rd_en),
    .i_lb_rd_data  (i_lb_rd_data),
    .o_pixel_data  (o_pixel_data),
    .o_pixel_valid (o_pixel_valid),
    .o_intr        (o_intr),
`ifdef LBC_LINE_COUNT_EN
    .o_line_cnt    (o_line_cnt),
`endif
    .o_overflow    (o_overflow)
  );

  // External line buffer model: each outputs {mem[rp], mem[rp+1], mem[rp+2]}, zero past the line end.
  logic [DW-1:0] mem [4][LW];
  int            wp [4];
  int            rp [4];

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 4; k++) begin
        wp[k] <= 0;
        rp[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (o_lb_wr_valid[k]) begin
          mem[k][wp[k]] <= o_lb_wr_data;
          wp[k] <= (wp[k] + 1) % LW;
        end
        if (o_lb_rd_en[k]) rp[k] <= (rp[k] + 1) % LW;
      end
    end
  end

  always_comb begin
    i_lb_rd_data = '0;
    for (int k = 0; k < 4; k++) begin
      for (int d = 0; d < 3; d++) begin
        if (rp[k] + d < LW) i_lb_rd_data[k*3*DW + (2-d)*DW +: DW] = mem[k][rp[k] + d];
      end
    end
  end

  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  logic [DW-1:0] hist [$];
  exp_t          exp_q [$];
  logic [3:0]    wr_q [$];
  logic [3:0]    rden_log [128];
  logic [3:0]    wrv_log [128];
  logic          ready_log [128];
  logic          ovf_log [128];
  logic          intr_log [128];
  int            fill_log [128];

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] hv(input int n, input int i);
    return (i < LW) ? hist[n*LW + i] : '0;
  endfunction

  function automatic logic [3*DW-1:0] trip(input int n, input int c);
    return {hv(n, c), hv(n, c+1), hv(n, c+2)};
  endfunction

  task automatic step(input bit vld);
    logic [DW-1:0] d;
    bit            acc;
    exp_t          e;
    int            n;
    @(posedge i_clk);
    #1;
    cyc++;
    d = DW'((hist.size() + 1) & 'hFF);
    i_pixel_valid = vld;
    i_pixel_data  = d;
    acc = vld && o_ready;
    if (acc) begin
      wr_q.push_back(4'b0001 << ((hist.size() / LW) % 4));
      hist.push_back(d);
      if (hist.size() % LW == 0 && hist.size() >= 3*LW) begin
        n = hist.size() / LW - 3;
        for (int c = 0; c < LW; c++) begin
          e.win  = {trip(n, c), trip(n+1, c), trip(n+2, c)};
          e.intr = (c == LW-1);
          exp_q.push_back(e);
        end
      end
    end
    @(negedge i_clk);
    if (cyc < 128) begin
      rden_log[cyc]  = o_lb_rd_en;
      wrv_log[cyc]   = o_lb_wr_valid;
      ready_log[cyc] = o_ready;
      ovf_log[cyc]   = o_overflow;
      intr_log[cyc]  = o_intr;
      fill_log[cyc]  = int'(dut.fill);
    end
    if (wr_q.size() > 0) chk("wr_valid", o_lb_wr_valid, wr_q.pop_front());
    else                 chk("wr_idle", o_lb_wr_valid, 4'b0000);
    if (o_pixel_valid) begin
      chk("win_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("window", o_pixel_data, e.win);
        chk("intr", o_intr, e.intr);
      end
    end else begin
      chk("intr_idle", o_intr, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int run;
    bit hit;
    i_rst_n = 1'b0;
    i_pixel_valid = 1'b0;
    i_pixel_data = '0;
    #12;
    chk("rst_pix_data", o_pixel_data, '0);
    chk("rst_pix_valid", o_pixel_valid, 1'b0);
    chk("rst_intr", o_intr, 1'b0);
    chk("rst_overflow", o_overflow, 1'b0);
    chk("rst_wr_valid", o_lb_wr_valid, 4'b0);
    chk("rst_rd_en", o_lb_rd_en, 4'b0);
    chk("rst_ready", o_ready, 1'b1);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Full-rate stream: first READ at cycle 13, fill peaks at 16 in cycle 33.
    for (int i = 0; i < 40; i++) step(1'b1);
    chk("wr_c1", wrv_log[1], 4'b0001);
    chk("wr_c4", wrv_log[4], 4'b0001);
    chk("wr_c5", wrv_log[5], 4'b0010);
    chk("wr_c13", wrv_log[13], 4'b1000);
    chk("rd_c12", rden_log[12], 4'b0000);
    for (int c = 13; c <= 16; c++) chk("rd_first", rden_log[c], 4'b0111);
    chk("rd_c17", rden_log[17], 4'b0000);
    chk("rd_c18", rden_log[18], 4'b1110);
    chk("intr_c16", intr_log[16], 1'b0);
    chk("intr_c17", intr_log[17], 1'b1);
    for (int c = 13; c <= 17; c++) chk("fill_hold", fill_log[c], 12);
    chk("ready_c32", ready_log[32], 1'b1);
    chk("ready_c33", ready_log[33], 1'b0);
    chk("drop_c33", wrv_log[33], 4'b0000);
    chk("ready_c34", ready_log[34], 1'b1);
    chk("ovf_c33", ovf_log[33], 1'b0);
    chk("ovf_c34", ovf_log[34], 1'b1);
    chk("ovf_sticky", ovf_log[40], 1'b1);

    // Reset in the middle of a READ when rd_cnt=2.
    run = 0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(1'b0);
      run = (o_lb_rd_en != 4'b0) ? run + 1 : 0;
      if (run == 3) hit = 1'b1;
    end
    chk("rst_wait", hit, 1'b1);
    chk("pre_rst_valid", o_pixel_valid, 1'b1);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", o_pixel_valid, 1'b0);
    chk("mid_rst_data", o_pixel_data, '0);
    chk("mid_rst_rd_en", o_lb_rd_en, 4'b0);
    chk("mid_rst_ovf", o_overflow, 1'b0);
    hist.delete();
    exp_q.delete();
    wr_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("rst_no_intr", o_intr, 1'b0);
    end
    i_rst_n = 1'b1;
    #1;
    chk("post_rst_ready", o_ready, 1'b1);
    chk("post_rst_idle", dut.state == lbc_pkg::IDLE, 1'b1);

    // Fresh traffic after reset: five lines, three windows rows emitted.
    cyc = 0;
    for (int i = 0; i < 20; i++) step(1'b1);
    for (int i = 0; i < 25; i++) step(1'b0);
    chk("rst_rd_c13", rden_log[13], 4'b0111);
    chk("rst_no_ovf", o_overflow, 1'b0);
`ifdef LBC_LINE_COUNT_EN
    chk("line_cnt_3", o_line_cnt, 16'd3);
    force dut.line_cnt = 16'hFFFF;
    #1;
    release dut.line_cnt;
    for (int i = 0; i < 4; i++) step(1'b1);
    for (int i = 0; i < 15; i++) step(1'b0);
    chk("line_cnt_wrap", o_line_cnt, 16'd0);
`endif
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
